// File: rtl/adxl362_spi_responder_if.sv
// ----------------------------------------------------------------------------
// adxl362_spi_responder_if
// Bundles the four SPI nets between an accelerometer controller (master)
// and the ADXL362 emulator (slave).
//
// Signals
//   sclk  master -> slave  SPI clock, idles low (mode 0)
//   ss_n  master -> slave  select, active low; one transaction per low period
//   mosi  master -> slave  data, changed by the master on SCLK fall
//   miso  slave  -> master data, changed by the slave on SCLK fall
//
// Protocol: mode 0, MSB first. Both ends shift out on SCLK fall and sample
// on SCLK rise. Pulling ss_n high ends the transaction at any bit position.
// ----------------------------------------------------------------------------
interface adxl362_spi_responder_if;
   logic sclk;
   logic ss_n;
   logic mosi;
   logic miso;

   modport master (output sclk, output ss_n, output mosi, input miso);
   modport slave  (input sclk, input ss_n, input mosi, output miso);
endinterface

// File: rtl/adxl362_spi_responder.sv
// ----------------------------------------------------------------------------
// adxl362_spi_responder
// SPI mode-0 slave that emulates the ADXL362 register interface so the
// accelerometer controller can run against known X/Y/Z/temperature values
// instead of the real sensor.
//
// Ports
//   clk        in   system clock (100 MHz)
//   reset      in   synchronous, active-high
//   spi        slave modport: sclk/ss_n/mosi in (async to clk), miso out
//   x/y/z/t_sample in 12  sample values, two's complement
//   wr_strobe  out  1-cycle pulse when a written data byte commits
//   wr_addr    out  address of the last committed write
//   wr_data    out  data of the last committed write
//   busy       out  high while a transaction is in progress
//   meas_mode  out  POWER_CTL(0x2D)[1:0] == 2'b10
//   dbg_state  out  current FSM state encoding
// ----------------------------------------------------------------------------
module adxl362_spi_responder #(
   parameter logic [7:0] REVID       = 8'h01,
   parameter int         SYNC_STAGES = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   adxl362_spi_responder_if.slave       spi,
   input  logic [11:0]                  x_sample,
   input  logic [11:0]                  y_sample,
   input  logic [11:0]                  z_sample,
   input  logic [11:0]                  t_sample,
   output logic                         wr_strobe,
   output logic [7:0]                   wr_addr,
   output logic [7:0]                   wr_data,
   output logic                         busy,
   output logic                         meas_mode,
   output logic [2:0]                   dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DATA   = 3'd3,
      ST_IGNORE = 3'd4
   } state_t;

   localparam logic [7:0] CMD_WRITE = 8'h0A;
   localparam logic [7:0] CMD_READ  = 8'h0B;

   // ---------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ---------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sclk_prev_q;
   logic                   ss_prev_q;

   logic sclk_s, ss_s, mosi_s;
   logic sclk_rise, sclk_fall, ss_fall;

   // The ss_n chain resets to 0 ("selected") on purpose: if reset hits in
   // the middle of a transaction the master still holds ss_n low, and the
   // responder must not see a fresh falling edge until ss_n goes high and
   // low again.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.ss_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign ss_fall   = ~ss_s & ss_prev_q;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t      state_q;
   logic [2:0]  bit_cnt_q;
   logic [7:0]  shift_in_q;
   logic [7:0]  shift_out_q;
   logic [7:0]  addr_q;
   logic        is_wr_q;
   logic        miso_q;
   logic        busy_q;
   logic        wr_strobe_q;
   logic [7:0]  wr_addr_q;
   logic [7:0]  wr_data_q;
   logic [11:0] x_shadow_q, y_shadow_q, z_shadow_q, t_shadow_q;
   logic [7:0]  regs_q [16];   // 0x20-0x2F

   logic [7:0]  byte_in;
   logic [7:0]  load_addr;
   logic [7:0]  rd_byte;

   // Byte as it stands once the current rising-edge bit is shifted in.
   assign byte_in = {shift_in_q[6:0], mosi_s};

   assign meas_mode = (regs_q[4'hD][1:0] == 2'b10);

   // ---------------------------------------------------------------------
   // Read mux. The byte to load is either the address just received (end
   // of the ADDR phase) or the next sequential address (end of a DATA byte).
   // ---------------------------------------------------------------------
   always_comb begin
      load_addr = (state_q == ST_ADDR) ? byte_in : addr_q + 8'd1;
      rd_byte   = 8'h00;
      case (load_addr)
         8'h00: rd_byte = 8'hAD;
         8'h01: rd_byte = 8'h1D;
         8'h02: rd_byte = 8'hF2;
         8'h03: rd_byte = REVID;
         8'h08: if (meas_mode) rd_byte = x_shadow_q[11:4];
         8'h09: if (meas_mode) rd_byte = y_shadow_q[11:4];
         8'h0A: if (meas_mode) rd_byte = z_shadow_q[11:4];
         8'h0B: rd_byte = {7'b0, meas_mode};
         8'h0E: if (meas_mode) rd_byte = x_shadow_q[7:0];
         8'h0F: if (meas_mode) rd_byte = {{4{x_shadow_q[11]}}, x_shadow_q[11:8]};
         8'h10: if (meas_mode) rd_byte = y_shadow_q[7:0];
         8'h11: if (meas_mode) rd_byte = {{4{y_shadow_q[11]}}, y_shadow_q[11:8]};
         8'h12: if (meas_mode) rd_byte = z_shadow_q[7:0];
         8'h13: if (meas_mode) rd_byte = {{4{z_shadow_q[11]}}, z_shadow_q[11:8]};
         8'h14: if (meas_mode) rd_byte = t_shadow_q[7:0];
         8'h15: if (meas_mode) rd_byte = {{4{t_shadow_q[11]}}, t_shadow_q[11:8]};
         default: begin
            if (load_addr[7:4] == 4'h2) rd_byte = regs_q[load_addr[3:0]];
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Transaction FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= 3'd0;
         shift_in_q  <= 8'h00;
         shift_out_q <= 8'h00;
         addr_q      <= 8'h00;
         is_wr_q     <= 1'b0;
         miso_q      <= 1'b0;
         busy_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= 8'h00;
         wr_data_q   <= 8'h00;
         x_shadow_q  <= 12'h000;
         y_shadow_q  <= 12'h000;
         z_shadow_q  <= 12'h000;
         t_shadow_q  <= 12'h000;
         for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      end else begin
         wr_strobe_q <= 1'b0;

         if (ss_s) begin
            // Deselected: any partial byte is dropped here.
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            miso_q    <= 1'b0;
            busy_q    <= 1'b0;
         end else if (ss_fall) begin
            state_q    <= ST_CMD;
            bit_cnt_q  <= 3'd0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b1;
            x_shadow_q <= x_sample;
            y_shadow_q <= y_sample;
            z_shadow_q <= z_sample;
            t_shadow_q <= t_sample;
         end else begin
            if (sclk_rise && (state_q == ST_CMD || state_q == ST_ADDR ||
                              state_q == ST_DATA)) begin
               shift_in_q <= byte_in;
               bit_cnt_q  <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  case (state_q)
                     ST_CMD: begin
                        if (byte_in == CMD_WRITE) begin
                           is_wr_q <= 1'b1;
                           state_q <= ST_ADDR;
                        end else if (byte_in == CMD_READ) begin
                           is_wr_q <= 1'b0;
                           state_q <= ST_ADDR;
                        end else begin
                           state_q <= ST_IGNORE;
                        end
                     end
                     ST_ADDR: begin
                        addr_q  <= byte_in;
                        state_q <= ST_DATA;
                        if (!is_wr_q) shift_out_q <= rd_byte;
                     end
                     ST_DATA: begin
                        addr_q <= addr_q + 8'd1;
                        if (is_wr_q) begin
                           wr_strobe_q <= 1'b1;
                           wr_addr_q   <= addr_q;
                           wr_data_q   <= byte_in;
                           if (addr_q == 8'h1F && byte_in == 8'h52) begin
                              // Soft reset of the stored register block.
                              for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
                           end else if (addr_q[7:4] == 4'h2) begin
                              regs_q[addr_q[3:0]] <= byte_in;
                           end
                        end else begin
                           shift_out_q <= rd_byte;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            // Read data leaves on the falling edge so it is stable well
            // before the master samples on the following rise.
            if (sclk_fall && state_q == ST_DATA && !is_wr_q) begin
               miso_q      <= shift_out_q[7];
               shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
         end
      end
   end

   assign spi.miso  = miso_q;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_adxl362_spi_responder
// Directed bench for the ADXL362 SPI responder. An SPI master is modelled by
// tasks driving the interface with each SCLK phase held 6 clk cycles.
// ----------------------------------------------------------------------------
module tb_adxl362_spi_responder;

   localparam int HALF = 6;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   adxl362_spi_responder_if spi_if ();

   logic [11:0] x_sample, y_sample, z_sample, t_sample;
   logic        wr_strobe;
   logic [7:0]  wr_addr, wr_data;
   logic        busy, meas_mode;
   logic [2:0]  dbg_state;

   adxl362_spi_responder #(.REVID(8'h01), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .spi       (spi_if.slave),
      .x_sample  (x_sample),
      .y_sample  (y_sample),
      .z_sample  (z_sample),
      .t_sample  (t_sample),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .meas_mode (meas_mode),
      .dbg_state (dbg_state)
   );

   // ---------------------------------------------------------------------
   // Scoreboard counters
   // ---------------------------------------------------------------------
   int tests_run  = 0;
   int tests_fail = 0;
   int strobe_cnt = 0;
   logic [7:0] rd_buf [0:7];

   // Counts every cycle wr_strobe is high, so a stuck strobe shows up too.
   always @(posedge clk) begin
      if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
   end

   task automatic check(input string tag, input logic [11:0] obs,
                        input logic [11:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // SPI master driver tasks
   // ---------------------------------------------------------------------
   task automatic spi_xfer(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_if.mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rx[i] = spi_if.miso;
         spi_if.sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_if.sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      spi_if.ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HALF) @(negedge clk);
      spi_if.ss_n = 1'b1;
      spi_if.mosi = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic do_read(input logic [7:0] addr, input int n);
      logic [7:0] rx;
      cs_low();
      spi_xfer(8'h0B, 8, rx);
      spi_xfer(addr, 8, rx);
      for (int k = 0; k < n; k++) begin
         spi_xfer(8'h00, 8, rx);
         rd_buf[k] = rx;
      end
      cs_high();
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
      logic [7:0] rx;
      cs_low();
      spi_xfer(8'h0A, 8, rx);
      spi_xfer(addr, 8, rx);
      spi_xfer(data, 8, rx);
      cs_high();
   endtask

   // ---------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      logic [7:0] rx;
      int s0;

      reset       = 1'b1;
      spi_if.sclk = 1'b0;
      spi_if.ss_n = 1'b1;
      spi_if.mosi = 1'b0;
      x_sample    = 12'hF80;
      y_sample    = 12'h7FF;
      z_sample    = 12'h8A0;
      t_sample    = 12'hA5C;
      repeat (5) @(negedge clk);
      check("reset_miso", spi_if.miso, 1'b0);
      check("reset_strobe", wr_strobe, 1'b0);
      check("reset_wr_addr", wr_addr, 8'h00);
      check("reset_wr_data", wr_data, 8'h00);
      check("reset_busy", busy, 1'b0);
      check("reset_meas", meas_mode, 1'b0);
      check("reset_state", dbg_state, 3'd0);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      // ID registers, 4-byte burst
      cs_low();
      spi_xfer(8'h0B, 8, rx);
      check("busy_in_xfer", busy, 1'b1);
      spi_xfer(8'h00, 8, rx);
      for (int k = 0; k < 4; k++) begin
         spi_xfer(8'h00, 8, rx);
         rd_buf[k] = rx;
      end
      cs_high();
      check("id_00", rd_buf[0], 8'hAD);
      check("id_01", rd_buf[1], 8'h1D);
      check("id_02", rd_buf[2], 8'hF2);
      check("id_03", rd_buf[3], 8'h01);
      check("busy_after", busy, 1'b0);

      // Address wrap 0xFF -> 0x00
      do_read(8'hFF, 2);
      check("wrap_ff", rd_buf[0], 8'h00);
      check("wrap_00", rd_buf[1], 8'hAD);

      // Standby: data registers read zero
      do_read(8'h0E, 2);
      check("stby_x_l", rd_buf[0], 8'h00);
      check("stby_x_h", rd_buf[1], 8'h00);

      // Enter measurement mode
      s0 = strobe_cnt;
      do_write(8'h2D, 8'h02);
      check("pwr_strobe_cnt", strobe_cnt - s0, 1);
      check("pwr_wr_addr", wr_addr, 8'h2D);
      check("pwr_wr_data", wr_data, 8'h02);
      check("pwr_meas", meas_mode, 1'b1);

      // 8-bit data regs and STATUS
      do_read(8'h08, 4);
      check("x_hi8", rd_buf[0], 8'hF8);
      check("y_hi8", rd_buf[1], 8'h7F);
      check("z_hi8", rd_buf[2], 8'h8A);
      check("status", rd_buf[3], 8'h01);

      // X low/high with sample change mid-transaction
      cs_low();
      spi_xfer(8'h0B, 8, rx);
      spi_xfer(8'h0E, 8, rx);
      spi_xfer(8'h00, 8, rx);
      check("x_l_snap", rx, 8'h80);
      x_sample = 12'h07F;
      spi_xfer(8'h00, 8, rx);
      check("x_h_snap", rx, 8'hFF);
      cs_high();
      do_read(8'h0E, 2);
      check("x_l_new", rd_buf[0], 8'h7F);
      check("x_h_new", rd_buf[1], 8'h00);
      do_read(8'h14, 2);
      check("t_l", rd_buf[0], 8'h5C);
      check("t_h", rd_buf[1], 8'hFA);

      // Full write then partial overwrite that must be dropped
      do_write(8'h2E, 8'h5A);
      s0 = strobe_cnt;
      cs_low();
      spi_xfer(8'h0A, 8, rx);
      spi_xfer(8'h2E, 8, rx);
      spi_xfer(8'hFF, 5, rx);
      cs_high();
      check("partial_no_strobe", strobe_cnt - s0, 0);
      do_read(8'h2E, 1);
      check("partial_reg_kept", rd_buf[0], 8'h5A);

      // Two-byte write crossing out of the stored block
      s0 = strobe_cnt;
      cs_low();
      spi_xfer(8'h0A, 8, rx);
      spi_xfer(8'h2F, 8, rx);
      spi_xfer(8'h11, 8, rx);
      spi_xfer(8'h22, 8, rx);
      cs_high();
      check("burst_strobes", strobe_cnt - s0, 2);
      check("burst_wr_addr", wr_addr, 8'h30);
      check("burst_wr_data", wr_data, 8'h22);
      do_read(8'h2F, 2);
      check("burst_2f", rd_buf[0], 8'h11);
      check("burst_30", rd_buf[1], 8'h00);

      // Unknown command is ignored
      s0 = strobe_cnt;
      cs_low();
      spi_xfer(8'h55, 8, rx);
      for (int k = 0; k < 3; k++) begin
         spi_xfer(8'hFF, 8, rx);
         rd_buf[k] = rx;
      end
      check("ign_state", dbg_state, 3'd4);
      cs_high();
      check("ign_b0", rd_buf[0], 8'h00);
      check("ign_b1", rd_buf[1], 8'h00);
      check("ign_b2", rd_buf[2], 8'h00);
      check("ign_no_strobe", strobe_cnt - s0, 0);
      do_read(8'h00, 1);
      check("after_ign", rd_buf[0], 8'hAD);

      // Soft reset via 0x1F = 0x52
      do_write(8'h1F, 8'h52);
      check("srst_wr_addr", wr_addr, 8'h1F);
      check("srst_wr_data", wr_data, 8'h52);
      check("srst_meas", meas_mode, 1'b0);
      do_read(8'h2D, 2);
      check("srst_2d", rd_buf[0], 8'h00);
      check("srst_2e", rd_buf[1], 8'h00);
      do_read(8'h0E, 2);
      check("srst_x_l", rd_buf[0], 8'h00);
      check("srst_x_h", rd_buf[1], 8'h00);

      // Reset in the middle of a read
      do_write(8'h2D, 8'h02);
      check("pre_rst_meas", meas_mode, 1'b1);
      cs_low();
      spi_xfer(8'h0B, 8, rx);
      spi_xfer(8'h00, 8, rx);
      spi_xfer(8'h00, 4, rx);
      check("mid_rx_hi", rx[7:4], 4'hA);
      repeat (4) @(negedge clk);
      check("pre_rst_miso", spi_if.miso, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_miso", spi_if.miso, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_meas", meas_mode, 1'b0);
      reset = 1'b0;
      s0 = strobe_cnt;
      spi_xfer(8'h00, 8, rx);
      check("post_rst_rx", rx, 8'h00);
      check("post_rst_busy", busy, 1'b0);
      cs_high();
      check("post_rst_strobe", strobe_cnt - s0, 0);
      do_read(8'h01, 1);
      check("post_rst_read", rd_buf[0], 8'h1D);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule
